// File: rtl/pipe_pkg.sv
// Shared constants, colours and FSM state type for the pipe drawing/position logic.
package pipe_pkg;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int PIPE_W_DEF = 8;
  localparam int GAP_H_DEF  = 20;

  localparam logic [2:0] COLOUR_PIPE = 3'b010;
  localparam logic [2:0] COLOUR_BG   = 3'b011;
  localparam logic [2:0] COLOUR_LIP  = 3'b110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    FINISH = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_pixel_colour.sv
// Combinational pixel colour for one (col,row) of the pipe relative to the opening top ly.
// Build option PIPE_DRAWER_LIP_EN paints the rows just above/below the opening in the lip colour.
module pipe_pixel_colour
  import pipe_pkg::*;
#(
  parameter int         PIPE_W      = PIPE_W_DEF,
  parameter int         GAP_H       = GAP_H_DEF,
  parameter logic [2:0] PIPE_COLOUR = COLOUR_PIPE,
  parameter logic [2:0] BG_COLOUR   = COLOUR_BG
) (
  input  logic [7:0] col_i,
  input  logic [6:0] row_i,
  input  logic [6:0] ly_i,
  output logic [2:0] colour_o
);

  logic [7:0] row8;
  logic [7:0] gap_lo;
  logic [7:0] gap_hi;
  logic       in_gap;
  logic       is_erase;

  // 8-bit compare so an opening near the bottom clips instead of wrapping to row 0
  assign row8     = {1'b0, row_i};
  assign gap_lo   = {1'b0, ly_i};
  assign gap_hi   = gap_lo + 8'(GAP_H);
  assign in_gap   = (row8 >= gap_lo) && (row8 < gap_hi);
  assign is_erase = (col_i == 8'(PIPE_W));

`ifdef PIPE_DRAWER_LIP_EN
  logic is_lip;
  assign is_lip = ((ly_i != 7'd0) && ((row8 + 8'd1) == gap_lo)) || (row8 == gap_hi);

  always_comb begin
    colour_o = PIPE_COLOUR;
    if (is_erase || in_gap) colour_o = BG_COLOUR;
    else if (is_lip)        colour_o = COLOUR_LIP;
  end
`else
  always_comb begin
    colour_o = PIPE_COLOUR;
    if (is_erase || in_gap) colour_o = BG_COLOUR;
  end
`endif

endmodule

// File: rtl/pipe_drawer.sv
// Streams a column-major redraw of the pipe (body, opening, trailing erase column) per game tick edge.
// Latency: first pixel 2 cycles after the tick edge, done 1 cycle after the last; option PIPE_DRAWER_LIP_EN.
module pipe_drawer
  import pipe_pkg::*;
#(
  parameter int         PIPE_W      = PIPE_W_DEF,
  parameter int         GAP_H       = GAP_H_DEF,
  parameter logic [2:0] PIPE_COLOUR = COLOUR_PIPE,
  parameter logic [2:0] BG_COLOUR   = COLOUR_BG
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       game_tick,
  input  logic [7:0] pipe_x,
  input  logic [6:0] pipe_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic       dropped
);

  localparam logic [7:0] LAST_COL = 8'(PIPE_W);
  localparam logic [6:0] LAST_ROW = 7'(SCREEN_H - 1);

  pipe_state_e state_q, state_d;
  logic [7:0]  lx_q, lx_d;
  logic [6:0]  ly_q, ly_d;
  logic [7:0]  col_q, col_d;
  logic [6:0]  row_q, row_d;
  logic        tick_prev_q;

  logic [7:0]  vga_x_q;
  logic [6:0]  vga_y_q;
  logic [2:0]  colour_q;
  logic        plot_q, busy_q, done_q, dropped_q;

  logic        req;
  logic [8:0]  sx;
  logic [2:0]  pix_colour;

  assign req = game_tick & ~tick_prev_q;
  assign sx  = {1'b0, lx_q} + {1'b0, col_q};

  pipe_pixel_colour #(
    .PIPE_W      (PIPE_W),
    .GAP_H       (GAP_H),
    .PIPE_COLOUR (PIPE_COLOUR),
    .BG_COLOUR   (BG_COLOUR)
  ) u_colour (
    .col_i    (col_q),
    .row_i    (row_q),
    .ly_i     (ly_q),
    .colour_o (pix_colour)
  );

  always_comb begin
    state_d = state_q;
    lx_d    = lx_q;
    ly_d    = ly_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = DRAW;
          lx_d    = pipe_x;
          ly_d    = pipe_y;
          col_d   = 8'd0;
          row_d   = 7'd0;
        end
      end
      DRAW: begin
        if (row_q == LAST_ROW) begin
          row_d = 7'd0;
          if (col_q == LAST_COL) state_d = FINISH;
          else                   col_d   = col_q + 8'd1;
        end else begin
          row_d = row_q + 7'd1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      lx_q        <= 8'd0;
      ly_q        <= 7'd0;
      col_q       <= 8'd0;
      row_q       <= 7'd0;
      tick_prev_q <= 1'b0;
      vga_x_q     <= 8'd0;
      vga_y_q     <= 7'd0;
      colour_q    <= BG_COLOUR;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lx_q        <= lx_d;
      ly_q        <= ly_d;
      col_q       <= col_d;
      row_q       <= row_d;
      tick_prev_q <= game_tick;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_q == FINISH);
      dropped_q   <= req && (state_q != IDLE);
      // Off-screen columns are still walked so frame length never depends on pipe_x
      plot_q      <= (state_q == DRAW) && (sx < 9'(SCREEN_W));
      if (state_q == DRAW) begin
        vga_x_q  <= sx[7:0];
        vga_y_q  <= row_q;
        colour_q <= pix_colour;
      end
    end
  end

  assign vga_x   = vga_x_q;
  assign vga_y   = vga_y_q;
  assign colour  = colour_q;
  assign plot    = plot_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign dropped = dropped_q;

endmodule
